// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, ALU opcodes, FSM state encoding and the
// latched command payload used by the ALU sequencer and its register file.
package alu_seq_pkg;

  localparam int unsigned DATA_W   = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned NUM_REGS = 4;

  // ALU mode encodings as understood by the gate-level ALU
  localparam logic [OP_W-1:0] OP_NOT_A = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD3  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND   = 3'b010;
  localparam logic [OP_W-1:0] OP_OR    = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b100;
  localparam logic [OP_W-1:0] OP_SHL   = 3'b101;
  localparam logic [OP_W-1:0] OP_ZERO  = 3'b110;
  localparam logic [OP_W-1:0] OP_ONES  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  // Command fields captured at the handshake
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [IDX_W-1:0] ra;
    logic [IDX_W-1:0] rb;
    logic [IDX_W-1:0] rc;
    logic [IDX_W-1:0] rd;
  } cmd_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 4 x 4-bit operand register file.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high clear
//   wr_en/wr_idx/wr_data  - single synchronous write port
//   rd_a/b/c_idx -> *_data - three combinational operand read ports
//   dbg_idx -> dbg_data   - combinational debug read port
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_a_idx,
  input  logic [IDX_W-1:0]  rd_b_idx,
  input  logic [IDX_W-1:0]  rd_c_idx,
  input  logic [IDX_W-1:0]  dbg_idx,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic [DATA_W-1:0] rd_c_data,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage with synchronous clear
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  assign rd_a_data = regs[rd_a_idx];
  assign rd_b_data = regs[rd_b_idx];
  assign rd_c_data = regs[rd_c_idx];
  assign dbg_data  = regs[dbg_idx];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequencing controller for the 4-bit, 8-mode gate-level ALU.
// Accepts one command at a time (valid/ready), drives the ALU from the
// operand register file, holds the drive for SETTLE_CYCLES, captures the
// result and writes it back to the destination register.
// Optional feature macro: ALU_SEQ_FLAGS_EN adds flag_zero/flag_carry.
// Ports:
//   clock, reset                      - rising-edge clock, sync active-high reset
//   cmd_valid/cmd_ready, cmd_op,
//   cmd_ra/rb/rc/rd                   - command handshake and fields
//   load_en/load_idx/load_data        - host register write (IDLE only)
//   alu_select/alu_a/alu_b/alu_c      - registered ALU drive
//   alu_regout/alu_carryout           - ALU results
//   done_valid/done_data/done_carry   - completion pulse and captured result
//   busy                              - inverse of cmd_ready out of reset
//   dbg_idx/dbg_data                  - combinational register-file read
//   flag_zero/flag_carry              - result flags (ALU_SEQ_FLAGS_EN only)
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [IDX_W-1:0]  cmd_ra,
  input  logic [IDX_W-1:0]  cmd_rb,
  input  logic [IDX_W-1:0]  cmd_rc,
  input  logic [IDX_W-1:0]  cmd_rd,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_data,
  output logic [OP_W-1:0]   alu_select,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_c,
  input  logic [DATA_W-1:0] alu_regout,
  input  logic              alu_carryout,
  output logic              done_valid,
  output logic [DATA_W-1:0] done_data,
  output logic              done_carry,
  output logic              busy,
  input  logic [IDX_W-1:0]  dbg_idx,
  output logic [DATA_W-1:0] dbg_data
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic              flag_zero,
  output logic              flag_carry
`endif
);

  // Counter only needs to hold SETTLE_CYCLES-1
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t            state;
  cmd_t              cmd;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              capture;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_a_data;
  logic [DATA_W-1:0] rd_b_data;
  logic [DATA_W-1:0] rd_c_data;

  assign accept  = cmd_valid & cmd_ready & (state == ST_IDLE);
  assign capture = (state == ST_CAPTURE);

  // Write port: result write-back in CAPTURE, host loads only in IDLE
  assign wr_en   = capture | ((state == ST_IDLE) & load_en);
  assign wr_idx  = capture ? cmd.rd : load_idx;
  assign wr_data = capture ? done_data : load_data;

  alu_seq_regfile u_regfile (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .rd_a_idx  (cmd.ra),
    .rd_b_idx  (cmd.rb),
    .rd_c_idx  (cmd.rc),
    .dbg_idx   (dbg_idx),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .rd_c_data (rd_c_data),
    .dbg_data  (dbg_data)
  );

  // Sequencer FSM, settle counter and all registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cmd        <= '0;
      cnt        <= '0;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      alu_select <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_c      <= '0;
      done_valid <= 1'b0;
      done_data  <= '0;
      done_carry <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
`endif
    end else begin
      done_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd       <= '{op: cmd_op, ra: cmd_ra, rb: cmd_rb, rc: cmd_rc, rd: cmd_rd};
            state     <= ST_ISSUE;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            // First IDLE cycle after reset raises ready here
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        ST_ISSUE: begin
          alu_select <= cmd.op;
          alu_a      <= rd_a_data;
          alu_b      <= rd_b_data;
          alu_c      <= rd_c_data;
          cnt        <= CNT_W'(SETTLE_CYCLES - 1);
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            // Sample on entry to CAPTURE so the result accompanies done_valid
            state      <= ST_CAPTURE;
            done_valid <= 1'b1;
            done_data  <= alu_regout;
            done_carry <= alu_carryout;
`ifdef ALU_SEQ_FLAGS_EN
            flag_zero  <= (alu_regout == '0);
            flag_carry <= alu_carryout;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer with a
// behavioural ALU model on the alu_* drive.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic              clock;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [IDX_W-1:0]  cmd_ra, cmd_rb, cmd_rc, cmd_rd;
  logic              load_en;
  logic [IDX_W-1:0]  load_idx;
  logic [DATA_W-1:0] load_data;
  logic [OP_W-1:0]   alu_select;
  logic [DATA_W-1:0] alu_a, alu_b, alu_c;
  logic [DATA_W-1:0] alu_regout;
  logic              alu_carryout;
  logic              done_valid;
  logic [DATA_W-1:0] done_data;
  logic              done_carry;
  logic              busy;
  logic [IDX_W-1:0]  dbg_idx;
  logic [DATA_W-1:0] dbg_data;
`ifdef ALU_SEQ_FLAGS_EN
  logic              flag_zero, flag_carry;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_q[$];

  alu_sequencer #(.SETTLE_CYCLES(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_ra       (cmd_ra),
    .cmd_rb       (cmd_rb),
    .cmd_rc       (cmd_rc),
    .cmd_rd       (cmd_rd),
    .load_en      (load_en),
    .load_idx     (load_idx),
    .load_data    (load_data),
    .alu_select   (alu_select),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_c        (alu_c),
    .alu_regout   (alu_regout),
    .alu_carryout (alu_carryout),
    .done_valid   (done_valid),
    .done_data    (done_data),
    .done_carry   (done_carry),
    .busy         (busy),
    .dbg_idx      (dbg_idx),
    .dbg_data     (dbg_data)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU
  logic [5:0] sum;
  always_comb begin
    sum          = 6'(alu_a) + 6'(alu_b) + 6'(alu_c);
    alu_regout   = '0;
    alu_carryout = 1'b0;
    case (alu_select)
      OP_NOT_A: alu_regout = ~alu_a;
      OP_ADD3:  begin alu_regout = sum[3:0]; alu_carryout = |sum[5:4]; end
      OP_AND:   alu_regout = alu_a & alu_b;
      OP_OR:    alu_regout = alu_a | alu_b;
      OP_XOR:   alu_regout = alu_a ^ alu_b;
      OP_SHL:   begin alu_regout = {alu_a[2:0], alu_c[0]}; alu_carryout = alu_a[3]; end
      OP_ZERO:  alu_regout = 4'h0;
      OP_ONES:  alu_regout = 4'hF;
      default:  alu_regout = 4'h0;
    endcase
  end

  // Cycle counter, accept timestamps, completion pulse counter
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset && cmd_valid && cmd_ready) acc_q.push_back(cyc);
    if (done_valid) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [1:0] idx, input logic [3:0] data);
    load_en   = 1'b1;
    load_idx  = idx;
    load_data = data;
    step();
    load_en   = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [1:0] rc, input logic [1:0] rd);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rc = rc; cmd_rd = rd;
    step();
    cmd_valid = 1'b0;
  endtask

  // Bounded wait for the completion pulse
  task automatic wait_done(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (done_valid) break;
      step();
    end
    check(tag, 8'(done_valid), 8'h1);
  endtask

  task automatic dbg_check(input string tag, input logic [1:0] idx, input logic [3:0] exp);
    dbg_idx = idx;
    #1;
    check(tag, 8'(dbg_data), 8'(exp));
  endtask

  initial begin
    int base;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0;
    cmd_rc = '0; cmd_rd = '0; load_en = 1'b0; load_idx = '0; load_data = '0;
    dbg_idx = '0;

    // Reset and idle
    step(); step();
    check("ready_in_reset", 8'(cmd_ready), 8'h0);
    check("busy_in_reset", 8'(busy), 8'h0);
    reset = 1'b0;
    step();
    check("ready_after_reset", 8'(cmd_ready), 8'h1);
    check("busy_after_reset", 8'(busy), 8'h0);
    check("done_valid_reset", 8'(done_valid), 8'h0);
    check("done_data_reset", 8'(done_data), 8'h0);
    check("alu_a_reset", 8'(alu_a), 8'h0);
    check("alu_sel_reset", 8'(alu_select), 8'h0);
    for (int i = 0; i < 4; i++) dbg_check("dbg_reset", 2'(i), 4'h0);

    // 9 + 3 + 1 = D, checked cycle by cycle
    load(2'd0, 4'h9); load(2'd1, 4'h3); load(2'd2, 4'h1);
    issue(OP_ADD3, 2'd0, 2'd1, 2'd2, 2'd3);          // E0
    check("ready_after_accept", 8'(cmd_ready), 8'h0);
    check("busy_after_accept", 8'(busy), 8'h1);
    step();                                          // E1
    check("e1_alu_a", 8'(alu_a), 8'h9);
    check("e1_alu_b", 8'(alu_b), 8'h3);
    check("e1_alu_c", 8'(alu_c), 8'h1);
    check("e1_alu_sel", 8'(alu_select), 8'h1);
    check("e1_no_done", 8'(done_valid), 8'h0);
    step();                                          // E2
    check("e2_no_done", 8'(done_valid), 8'h0);
    step();                                          // E3
    check("e3_no_done", 8'(done_valid), 8'h0);
    step();                                          // E4
    check("e4_done", 8'(done_valid), 8'h1);
    check("add_data", 8'(done_data), 8'hD);
    check("add_carry", 8'(done_carry), 8'h0);
`ifdef ALU_SEQ_FLAGS_EN
    check("add_flag_zero", 8'(flag_zero), 8'h0);
`endif
    step();                                          // E5
    check("e5_done_clear", 8'(done_valid), 8'h0);
    check("e5_ready", 8'(cmd_ready), 8'h1);
    check("e5_data_held", 8'(done_data), 8'hD);
    dbg_check("wb_r3", 2'd3, 4'hD);

    // F + 1 + 0 wraps to 0 with carry
    load(2'd0, 4'hF); load(2'd1, 4'h1); load(2'd2, 4'h0);
    issue(OP_ADD3, 2'd0, 2'd1, 2'd2, 2'd3);
    wait_done("wrap_done");
    check("wrap_data", 8'(done_data), 8'h0);
    check("wrap_carry", 8'(done_carry), 8'h1);
`ifdef ALU_SEQ_FLAGS_EN
    check("wrap_flag_zero", 8'(flag_zero), 8'h1);
    check("wrap_flag_carry", 8'(flag_carry), 8'h1);
`endif
    step();

    // Back-to-back with cmd_valid held; a WAIT-time load must be dropped
    base = acc_q.size();
    cmd_valid = 1'b1; cmd_op = OP_ONES; cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_rc = 2'd2; cmd_rd = 2'd3;
    for (int i = 0; i < 10; i++) begin
      if (acc_q.size() > base) break;
      step();
    end
    check("held_first_accept", 8'(acc_q.size() > base), 8'h1);
    step();                                          // now in WAIT
    load_en = 1'b1; load_idx = 2'd0; load_data = 4'h6;
    step();
    load_en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (acc_q.size() >= base + 3) break;
      step();
    end
    cmd_valid = 1'b0;
    check("held_three_accepts", 8'(acc_q.size() >= base + 3), 8'h1);
    if (acc_q.size() >= base + 3) begin
      check("accept_gap_1", 8'(acc_q[base+1] - acc_q[base]), 8'd6);
      check("accept_gap_2", 8'(acc_q[base+2] - acc_q[base+1]), 8'd6);
    end
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) break;
      step();
    end
    check("held_back_idle", 8'(cmd_ready), 8'h1);
    dbg_check("wait_load_dropped", 2'd0, 4'hF);
    dbg_check("ones_wb_r3", 2'd3, 4'hF);

    // Reset during the second WAIT cycle aborts the command
    load(2'd0, 4'h2);
    issue(OP_ADD3, 2'd0, 2'd1, 2'd2, 2'd1);          // E0
    step();                                          // E1: first WAIT cycle
    step();                                          // E2: second WAIT cycle
    base = done_cnt;
    reset = 1'b1;
    step();
    check("abort_ready_in_reset", 8'(cmd_ready), 8'h0);
    reset = 1'b0;
    step();
    check("abort_ready", 8'(cmd_ready), 8'h1);
    check("abort_busy", 8'(busy), 8'h0);
    step(); step(); step(); step();
    check("abort_no_done", 8'(done_cnt - base), 8'h0);
    check("abort_alu_a", 8'(alu_a), 8'h0);
    check("abort_alu_sel", 8'(alu_select), 8'h0);
    check("abort_done_data", 8'(done_data), 8'h0);
    check("abort_done_carry", 8'(done_carry), 8'h0);
`ifdef ALU_SEQ_FLAGS_EN
    check("abort_flag_zero", 8'(flag_zero), 8'h0);
    check("abort_flag_carry", 8'(flag_carry), 8'h0);
`endif
    for (int i = 0; i < 4; i++) dbg_check("abort_regs", 2'(i), 4'h0);

    // Same-edge load and accept: the command sees the new value
    load_en = 1'b1; load_idx = 2'd0; load_data = 4'hA;
    issue(OP_NOT_A, 2'd0, 2'd0, 2'd0, 2'd1);
    load_en = 1'b0;
    step();
    check("same_edge_alu_a", 8'(alu_a), 8'hA);
    wait_done("not_done");
    check("not_data", 8'(done_data), 8'h5);
    check("not_carry", 8'(done_carry), 8'h0);
    step();
    dbg_check("not_wb_r1", 2'd1, 4'h5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
